// File: rtl/regs_arbiter.sv
// regs_arbiter: round-robin sequencer that shares one register-memory master
// port among NUM_REQ requesters. At most one access is in flight. Every output
// is registered. Strobes are held until the slave acknowledges or the timeout
// expires.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; arbitrate among req_valid starting at rr_ptr
// BUSY  | strobe/addr/data held to slave, waiting for ack or timeout
// RESP  | one-cycle resp_valid pulse to the owner; rr_ptr moves past it
module regs_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_DEPTH = 16,
    parameter  int DATA_WIDTH = 8,
    parameter  int TIMEOUT    = 1000,
    localparam int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic                          resp_err,
    output logic [DATA_WIDTH-1:0]         resp_rdata,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          write_en,
    output logic                          read_en,
    output logic [ADDR_WIDTH-1:0]         addr,
    output logic [DATA_WIDTH-1:0]         write_data,
    input  logic [DATA_WIDTH-1:0]         read_data,
    input  logic                          data_ready,
    input  logic                          write_done
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    // Terminal count: the BUSY cycle on which a missing ack becomes a timeout.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        rr_ptr_nxt;
    logic [IDX_W-1:0]        cur_idx;
    logic [IDX_W-1:0]        cur_idx_nxt;
    logic [CNT_W-1:0]        tmo_cnt;
    logic [CNT_W-1:0]        tmo_cnt_nxt;

    logic [NUM_REQ-1:0]      resp_valid_nxt;
    logic                    resp_err_nxt;
    logic [DATA_WIDTH-1:0]   resp_rdata_nxt;
    logic [NUM_REQ-1:0]      grant_nxt;
    logic                    write_en_nxt;
    logic                    read_en_nxt;
    logic [ADDR_WIDTH-1:0]   addr_nxt;
    logic [DATA_WIDTH-1:0]   write_data_nxt;

    logic                    arb_found;
    logic [IDX_W-1:0]        arb_idx;
    logic [IDX_W-1:0]        slot;
    logic                    arb_write;
    logic [ADDR_WIDTH-1:0]   arb_addr;
    logic [DATA_WIDTH-1:0]   arb_wdata;

    logic                    ack;
    logic [IDX_W-1:0]        idx_after_cur;

    // Requester index offset positions above base, wrapping at NUM_REQ.
    function automatic logic [IDX_W-1:0] rr_slot(input logic [IDX_W-1:0] base,
                                                 input int               offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IDX_W'(sum);
    endfunction

    // Only the acknowledge that matches the access type counts.
    assign ack = write_en ? write_done : data_ready;

    // The pointer moves one past the owner, so the owner is checked last next time.
    assign idx_after_cur = (cur_idx == IDX_LAST) ? '0 : cur_idx + 1'b1;

    // Round-robin pick: first active request at or above rr_ptr, with wrap.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        slot      = '0;
        arb_write = 1'b0;
        arb_addr  = '0;
        arb_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            slot = rr_slot(rr_ptr, i);
            if (!arb_found && req_valid[slot]) begin
                arb_found = 1'b1;
                arb_idx   = slot;
                arb_write = req_write[slot];
                arb_addr  = req_addr[int'(slot)*ADDR_WIDTH +: ADDR_WIDTH];
                arb_wdata = req_wdata[int'(slot)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_nxt      = state;
        rr_ptr_nxt     = rr_ptr;
        cur_idx_nxt    = cur_idx;
        tmo_cnt_nxt    = tmo_cnt;
        grant_nxt      = grant;
        write_en_nxt   = write_en;
        read_en_nxt    = read_en;
        addr_nxt       = addr;
        write_data_nxt = write_data;
        resp_valid_nxt = '0;
        resp_err_nxt   = 1'b0;
        resp_rdata_nxt = '0;

        unique case (state)
            IDLE: begin
                if (arb_found) begin
                    state_nxt      = BUSY;
                    cur_idx_nxt    = arb_idx;
                    grant_nxt      = NUM_REQ'(1) << arb_idx;
                    write_en_nxt   = arb_write;
                    read_en_nxt    = !arb_write;
                    addr_nxt       = arb_addr;
                    write_data_nxt = arb_wdata;
                    tmo_cnt_nxt    = '0;
                end
            end

            BUSY: begin
                // An ack on the terminal-count cycle still completes normally.
                if (ack) begin
                    state_nxt      = RESP;
                    write_en_nxt   = 1'b0;
                    read_en_nxt    = 1'b0;
                    addr_nxt       = '0;
                    write_data_nxt = '0;
                    resp_valid_nxt = grant;
                    resp_rdata_nxt = read_en ? read_data : '0;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt      = RESP;
                    write_en_nxt   = 1'b0;
                    read_en_nxt    = 1'b0;
                    addr_nxt       = '0;
                    write_data_nxt = '0;
                    resp_valid_nxt = grant;
                    resp_err_nxt   = 1'b1;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 1'b1;
                end
            end

            RESP: begin
                state_nxt  = IDLE;
                grant_nxt  = '0;
                rr_ptr_nxt = idx_after_cur;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, bookkeeping and output registers; reset aborts any access silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cur_idx    <= '0;
            tmo_cnt    <= '0;
            grant      <= '0;
            write_en   <= 1'b0;
            read_en    <= 1'b0;
            addr       <= '0;
            write_data <= '0;
            resp_valid <= '0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            cur_idx    <= cur_idx_nxt;
            tmo_cnt    <= tmo_cnt_nxt;
            grant      <= grant_nxt;
            write_en   <= write_en_nxt;
            read_en    <= read_en_nxt;
            addr       <= addr_nxt;
            write_data <= write_data_nxt;
            resp_valid <= resp_valid_nxt;
            resp_err   <= resp_err_nxt;
            resp_rdata <= resp_rdata_nxt;
        end
    end

endmodule
